// File: rtl/preparser_dispatch.sv
// preparser_dispatch: round-robin dispatch of preparser slices onto parser lanes; one register stage (load at N, offered at N+1),
// upstream stalls via o_in_ready while the held slice is unaccepted. Optional PREPARSER_DISPATCH_STAT_EN adds saturating slice/stall counters.
module preparser_dispatch #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2,
  parameter int SEQ_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [143:0]         i_in_data,
  input  logic [15:0]          i_in_token_pos,
  input  logic [16:0]          i_in_address,
  input  logic [2:0]           i_in_garbage,
  input  logic                 i_in_start_lit,
  input  logic                 i_in_last,
  output logic [NUM_LANES-1:0] o_lane_valid,
  input  logic [NUM_LANES-1:0] i_lane_ready,
  input  logic [NUM_LANES-1:0] i_lane_idle,
  output logic [143:0]         o_lane_data,
  output logic [15:0]          o_lane_token_pos,
  output logic [16:0]          o_lane_address,
  output logic [2:0]           o_lane_garbage,
  output logic                 o_lane_start_lit,
  output logic [SEQ_W-1:0]     o_lane_seq,
  output logic                 o_busy,
  output logic                 o_block_done
`ifdef PREPARSER_DISPATCH_STAT_EN
  ,
  output logic [31:0]          o_stat_slices,
  output logic [31:0]          o_stat_stall
`endif
);

  typedef struct packed {
    logic [143:0] data;
    logic [15:0]  token_pos;
    logic [16:0]  address;
    logic [2:0]   garbage;
    logic         start_lit;
  } slice_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_out_vld;
  logic [LANE_W-1:0]  r_out_sel;
  logic [LANE_W-1:0]  r_rr_ptr;
  logic [LANE_W-1:0]  w_sel;
  logic [LANE_W-1:0]  w_rr_nxt;
  slice_t             r_payload;
  slice_t             w_in_slice;
  logic [SEQ_W-1:0]   r_seq;
  logic [SEQ_W-1:0]   r_lane_seq;
  logic               w_out_accept;
  logic               w_in_ready;
  logic               w_load;
  logic               w_busy;
  logic               w_block_done;

  assign w_in_slice   = '{data: i_in_data, token_pos: i_in_token_pos, address: i_in_address,
                          garbage: i_in_garbage, start_lit: i_in_start_lit};
  assign w_out_accept = r_out_vld & i_lane_ready[r_out_sel];
  assign w_load       = i_in_valid & w_in_ready;

  // Rotating search from r_rr_ptr; falls back to r_rr_ptr when no lane is ready.
  always_comb begin
    int                idx;
    int                nxt;
    logic              found;
    logic [LANE_W-1:0] w_idx;
    idx   = 0;
    nxt   = 0;
    found = 1'b0;
    w_idx = '0;
    w_sel = r_rr_ptr;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      w_idx = LANE_W'(idx);
      if (!found && i_lane_ready[w_idx]) begin
        w_sel = w_idx;
        found = 1'b1;
      end
    end
    nxt = int'(w_sel) + 1;
    if (nxt >= NUM_LANES) nxt = 0;
    w_rr_nxt = LANE_W'(nxt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    w_block_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = ~r_out_vld | w_out_accept;
        if (i_in_valid && w_in_ready) w_state_nxt = i_in_last ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        w_busy     = 1'b1;
        w_in_ready = ~r_out_vld | w_out_accept;
        if (i_in_valid && w_in_ready && i_in_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (!r_out_vld && (&i_lane_idle)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_block_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A held slice never changes lane; the DONE clear cannot collide with a load since in_ready=0 there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_vld  <= 1'b0;
      r_out_sel  <= '0;
      r_payload  <= '0;
      r_lane_seq <= '0;
      r_seq      <= '0;
      r_rr_ptr   <= '0;
    end else if (w_load) begin
      r_out_vld  <= 1'b1;
      r_out_sel  <= w_sel;
      r_payload  <= w_in_slice;
      r_lane_seq <= r_seq;
      r_seq      <= r_seq + SEQ_W'(1);
      r_rr_ptr   <= w_rr_nxt;
    end else begin
      if (w_out_accept) r_out_vld <= 1'b0;
      if (r_state == S_DONE) begin
        r_seq    <= '0;
        r_rr_ptr <= '0;
      end
    end
  end

  always_comb begin
    o_lane_valid = '0;
    if (r_out_vld) o_lane_valid[r_out_sel] = 1'b1;
  end

  assign o_in_ready       = w_in_ready;
  assign o_lane_data      = r_payload.data;
  assign o_lane_token_pos = r_payload.token_pos;
  assign o_lane_address   = r_payload.address;
  assign o_lane_garbage   = r_payload.garbage;
  assign o_lane_start_lit = r_payload.start_lit;
  assign o_lane_seq       = r_lane_seq;
  assign o_busy           = w_busy;
  assign o_block_done     = w_block_done;

`ifdef PREPARSER_DISPATCH_STAT_EN
  logic [31:0] r_stat_slices;
  logic [31:0] r_stat_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_slices <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_out_accept && (r_stat_slices != '1)) r_stat_slices <= r_stat_slices + 32'd1;
      if (r_out_vld && !w_out_accept && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign o_stat_slices = r_stat_slices;
  assign o_stat_stall  = r_stat_stall;
`else
  // statistics counters are absent in this build
`endif

endmodule

// File: tb/tb_preparser_dispatch.sv
// Directed bench for preparser_dispatch with a transaction-level reference model and literal spot checks.
module tb_preparser_dispatch;

  typedef struct packed {
    logic [143:0] data;
    logic [15:0]  tok;
    logic [16:0]  addr;
    logic [2:0]   garb;
    logic         slit;
  } slice_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [143:0] in_data;
  logic [15:0]  in_token_pos;
  logic [16:0]  in_address;
  logic [2:0]   in_garbage;
  logic         in_start_lit;
  logic         in_last;
  logic [3:0]   lane_valid;
  logic [3:0]   lane_ready;
  logic [3:0]   lane_idle;
  logic [143:0] lane_data;
  logic [15:0]  lane_token_pos;
  logic [16:0]  lane_address;
  logic [2:0]   lane_garbage;
  logic         lane_start_lit;
  logic [15:0]  lane_seq;
  logic         busy;
  logic         block_done;
`ifdef PREPARSER_DISPATCH_STAT_EN
  logic [31:0]  stat_slices;
  logic [31:0]  stat_stall;
`endif

  preparser_dispatch #(.NUM_LANES(4), .LANE_W(2), .SEQ_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_token_pos(in_token_pos), .i_in_address(in_address),
    .i_in_garbage(in_garbage), .i_in_start_lit(in_start_lit), .i_in_last(in_last),
    .o_lane_valid(lane_valid), .i_lane_ready(lane_ready), .i_lane_idle(lane_idle),
    .o_lane_data(lane_data), .o_lane_token_pos(lane_token_pos), .o_lane_address(lane_address),
    .o_lane_garbage(lane_garbage), .o_lane_start_lit(lane_start_lit), .o_lane_seq(lane_seq),
    .o_busy(busy), .o_block_done(block_done)
`ifdef PREPARSER_DISPATCH_STAT_EN
    , .o_stat_slices(stat_slices), .o_stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_stall = 0;
  int cyc = 0;
  int lg_lane[$];
  int lg_seq[$];
  int done_cyc[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic slice_t mk(input int k);
    slice_t s;
    s.data = {9{16'(k)}};
    s.tok  = 16'(k) ^ 16'hA5A5;
    s.addr = 17'(k * 3);
    s.garb = 3'(k);
    s.slit = 1'(k);
    return s;
  endfunction

  // Reference model: one held slice, a next-lane pointer, a sequence counter and a block phase
  // (0 idle, 1 streaming, 2 waiting for lanes to drain, 3 completion pulse).
  bit          m_on = 1'b0;
  int          m_phase;
  bit          m_hv;
  int          m_hlane;
  logic [15:0] m_hseq;
  slice_t      m_h;
  int          m_rr;
  logic [15:0] m_seq;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit   acc_out;
    bit   ir;
    int   pick;
    int   ln;
    int   nphase;
    slice_t cur;
    // observe lane handshakes
    if (lane_valid != 4'b0) begin
      ln = 0;
      for (int i = 0; i < 4; i++) if (lane_valid[i]) ln = i;
      if (lane_ready[ln]) begin
        lg_lane.push_back(ln);
        lg_seq.push_back(int'(lane_seq));
      end
    end
    if (block_done) done_cyc.push_back(cyc);

    acc_out = m_hv && lane_ready[m_hlane];
    ir      = (m_phase < 2) && (!m_hv || acc_out);
    if (m_on) begin
      chk("lane_valid", lane_valid, m_hv ? (4'b1 << m_hlane) : 4'b0);
      chk("in_ready", in_ready, ir);
      chk("busy", busy, (m_phase == 1) || (m_phase == 2));
      chk("block_done", block_done, m_phase == 3);
      if (m_hv) begin
        chk("lane_seq", lane_seq, m_hseq);
        chk("payload", {lane_data, lane_token_pos, lane_address, lane_garbage, lane_start_lit}, m_h);
      end
    end

    if (rst) begin
      m_on = 1'b1; m_phase = 0; m_hv = 1'b0; m_hlane = 0; m_hseq = '0; m_h = '0; m_rr = 0; m_seq = '0;
    end else if (m_on) begin
      cur    = '{data: in_data, tok: in_token_pos, addr: in_address, garb: in_garbage, slit: in_start_lit};
      nphase = m_phase;
      if (m_phase < 2 && in_valid && ir) nphase = in_last ? 2 : 1;
      else if (m_phase == 2 && !m_hv && (&lane_idle)) nphase = 3;
      else if (m_phase == 3) begin nphase = 0; m_rr = 0; m_seq = '0; end
      if (in_valid && ir) begin
        pick = m_rr;
        for (int j = 0; j < 4; j++) begin
          if (lane_ready[(m_rr + j) % 4]) begin pick = (m_rr + j) % 4; break; end
        end
        m_hv = 1'b1; m_hlane = pick; m_hseq = m_seq; m_h = cur;
        m_rr = (pick + 1) % 4;
        m_seq = m_seq + 16'd1;
      end else if (acc_out) begin
        m_hv = 1'b0;
      end
      m_phase = nphase;
    end
  end

  task automatic put(input int k, input bit last);
    slice_t s;
    s = mk(k);
    in_valid = 1'b1; in_data = s.data; in_token_pos = s.tok; in_address = s.addr;
    in_garbage = s.garb; in_start_lit = s.slit; in_last = last;
  endtask

  task automatic send(input int k, input bit last);
    put(k, last);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      n_stall++;
      if (t >= 1000) begin
        total++; bad++;
        $display("FAIL send_timeout slice=%0d never accepted", k);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk); @(posedge clk); #1;
  endtask

  initial begin
    int e1[8];
    int st0;
    int tidle;
    int base;
    slice_t s12;
    e1 = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_token_pos = '0; in_address = '0;
    in_garbage = '0; in_start_lit = 1'b0; in_last = 1'b0; lane_ready = 4'hF; lane_idle = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_lane_valid", lane_valid, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", block_done, 1'b0);
    chk("rst_lane_seq", lane_seq, 16'h0);
    chk("rst_lane_data", lane_data, 144'h0);
    @(posedge clk); #1;

    // back-to-back stream, all lanes ready
    st0 = n_stall;
    for (int k = 0; k < 8; k++) send(k, 1'b0);
    idle_cycle();
    chk("t1_no_bubble", n_stall - st0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t1_lane", lg_lane[i], e1[i]);
      chk("t1_seq", lg_seq[i], i);
    end

    // skip a busy lane: pointer at 2 with lane 2 not ready
    send(8, 1'b0);
    send(9, 1'b0);
    lane_ready = 4'b1011;
    send(10, 1'b0);
    send(11, 1'b0);
    lane_ready = 4'hF;
    idle_cycle();
    chk("t2_lane8", lg_lane[8], 0);
    chk("t2_lane9", lg_lane[9], 1);
    chk("t2_lane10", lg_lane[10], 3);
    chk("t2_lane11", lg_lane[11], 0);

    // no lane ready: slice parks on the pointer lane and holds
    lane_ready = 4'h0;
    send(12, 1'b0);
    s12 = mk(12);
    put(13, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_hold_valid", lane_valid, 4'b0010);
      chk("t3_hold_ready", in_ready, 1'b0);
      chk("t3_hold_data", lane_data, s12.data);
    end
    @(posedge clk); #1;
    lane_ready = 4'hF;
    send(13, 1'b0);
    idle_cycle();
    chk("t3_lane12", lg_lane[12], 1);
    chk("t3_lane13", lg_lane[13], 2);

    // end of block with lanes busy for a while; next slice waits through drain
    send(14, 1'b0);
    send(15, 1'b1);
    put(16, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t4_drain_ready", in_ready, 1'b0);
      chk("t4_drain_busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    lane_idle = 4'hF;
    tidle = cyc;
    send(16, 1'b0);
    idle_cycle();
    chk("t4_done_count", done_cyc.size(), 1);
    chk("t4_done_time", done_cyc[0], tidle + 1);
    chk("t4_new_lane", lg_lane[16], 0);
    chk("t4_new_seq", lg_seq[16], 0);

    // sequence tag wrap within one block
    for (int k = 17; k <= 16 + 65536; k++) send(k, 1'b0);
    idle_cycle();
    base = 16 + 65535;
    chk("t5_seq_ffff", lg_seq[base], 32'h0000FFFF);
    chk("t5_seq_wrap", lg_seq[base + 1], 0);

    // reset while a slice is held
    lane_ready = 4'h0;
    send(70000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_lane_valid", lane_valid, 4'b0);
    chk("t6_busy", busy, 1'b0);
`ifdef PREPARSER_DISPATCH_STAT_EN
    chk("t6_stat_slices", stat_slices, 32'h0);
    chk("t6_stat_stall", stat_stall, 32'h0);
`endif
    @(posedge clk); #1;

    // single-slice block straight from idle
    lane_ready = 4'hF;
    base = lg_lane.size();
    send(5, 1'b1);
    repeat (4) idle_cycle();
    chk("t7_lane", lg_lane[base], 0);
    chk("t7_seq", lg_seq[base], 0);
    chk("t7_done_count", done_cyc.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
